kmeans_centroid_sched: RTL and testbench

Centroid-update scheduler for the 7-cluster k-means engine. On each end-of-pass pulse from the assignment FSM, it snapshots the per-cluster coordinate sums and counts. It then runs all 21 mean computations (7 clusters × x/y/z) through one shared 1-bit-per-cycle restoring divider and writes the results into the centroid register file that feeds the distance units. It also owns initial centroid loading and reports busy/done, so the sequencer can stall the next pass until every centroid is final.

---
 rtl/kmeans_centroid_sched_if.sv | 33 +++
 rtl/kmeans_centroid_sched.sv | 175 +++++++++++++++++
 tb/tb_kmeans_centroid_sched.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/kmeans_centroid_sched_if.sv
// Handshake and data bundle between the k-means sequencer and the centroid-update scheduler.
interface kmeans_centroid_sched_if #(
    parameter int SUMW = 16,
    parameter int CNTW = 6
);
    logic              start;
    logic [7*SUMW-1:0] sum_x;
    logic [7*SUMW-1:0] sum_y;
    logic [7*SUMW-1:0] sum_z;
    logic [7*CNTW-1:0] cnt;
    logic              init_we;
    logic [2:0]        init_sel;
    logic [7:0]        init_x;
    logic [7:0]        init_y;
    logic [7:0]        init_z;
    logic [55:0]       cx;
    logic [55:0]       cy;
    logic [55:0]       cz;
    logic              busy;
    logic              done;

    modport master (
        output start, sum_x, sum_y, sum_z, cnt,
        output init_we, init_sel, init_x, init_y, init_z,
        input  cx, cy, cz, busy, done
    );

    modport slave (
        input  start, sum_x, sum_y, sum_z, cnt,
        input  init_we, init_sel, init_x, init_y, init_z,
        output cx, cy, cz, busy, done
    );
endinterface

// File: rtl/kmeans_centroid_sched.sv
// Centroid-update scheduler: snapshots 7 clusters of sums/counts and computes all 21 means
// through one shared restoring divider, writing saturated 8-bit results into the centroid file.
module kmeans_centroid_sched #(
    parameter int SUMW = 16,
    parameter int CNTW = 6
) (
    input logic                     clk,
    input logic                     rst,
    kmeans_centroid_sched_if.slave  bus
);
    localparam int BW = $clog2(SUMW);

    typedef enum logic [2:0] {IDLE, CHECK, LOAD, DIV, WRITE, FINISH} state_t;

    state_t            state_q, state_d;
    logic [2:0]        k_q, k_d;
    logic [1:0]        a_q, a_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [SUMW-1:0]   div_q, div_d;
    logic [SUMW-1:0]   quo_q, quo_d;
    logic [CNTW:0]     rem_q, rem_d;
    logic [SUMW-1:0]   sx_q [7];
    logic [SUMW-1:0]   sx_d [7];
    logic [SUMW-1:0]   sy_q [7];
    logic [SUMW-1:0]   sy_d [7];
    logic [SUMW-1:0]   sz_q [7];
    logic [SUMW-1:0]   sz_d [7];
    logic [CNTW-1:0]   cnt_q [7];
    logic [CNTW-1:0]   cnt_d [7];
    logic [55:0]       cx_q, cx_d, cy_q, cy_d, cz_q, cz_d;

    logic [CNTW-1:0]   cur_cnt;
    logic [CNTW:0]     rem_sh;
    logic              rem_ge;
    logic [7:0]        res;

    // remainder stays below the divisor, so its low CNTW bits carry all information
    always_comb begin
        cur_cnt = cnt_q[k_q];
        rem_sh  = {rem_q[CNTW-1:0], div_q[bit_q]};
        rem_ge  = (rem_sh >= {1'b0, cur_cnt});
        res     = (|quo_q[SUMW-1:8]) ? 8'hFF : quo_q[7:0];
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        bit_d   = bit_q;
        div_d   = div_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        sz_d    = sz_q;
        cnt_d   = cnt_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cz_d    = cz_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    for (int unsigned i = 0; i < 7; i++) begin
                        sx_d[i]  = bus.sum_x[SUMW*i +: SUMW];
                        sy_d[i]  = bus.sum_y[SUMW*i +: SUMW];
                        sz_d[i]  = bus.sum_z[SUMW*i +: SUMW];
                        cnt_d[i] = bus.cnt[CNTW*i +: CNTW];
                    end
                    k_d     = '0;
                    a_d     = '0;
                    state_d = CHECK;
                end else if (bus.init_we && (bus.init_sel != 3'd7)) begin
                    cx_d[{bus.init_sel, 3'b000} +: 8] = bus.init_x;
                    cy_d[{bus.init_sel, 3'b000} +: 8] = bus.init_y;
                    cz_d[{bus.init_sel, 3'b000} +: 8] = bus.init_z;
                end
            end
            CHECK: begin
                if (cur_cnt == '0) begin
                    if (k_q == 3'd6) begin
                        state_d = FINISH;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end else begin
                    a_d     = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                unique case (a_q)
                    2'd0:    div_d = sx_q[k_q];
                    2'd1:    div_d = sy_q[k_q];
                    default: div_d = sz_q[k_q];
                endcase
                rem_d   = '0;
                quo_d   = '0;
                bit_d   = BW'(SUMW - 1);
                state_d = DIV;
            end
            DIV: begin
                rem_d        = rem_ge ? (rem_sh - {1'b0, cur_cnt}) : rem_sh;
                quo_d[bit_q] = rem_ge;
                if (bit_q == '0) begin
                    state_d = WRITE;
                end else begin
                    bit_d = bit_q - BW'(1);
                end
            end
            WRITE: begin
                unique case (a_q)
                    2'd0:    cx_d[{k_q, 3'b000} +: 8] = res;
                    2'd1:    cy_d[{k_q, 3'b000} +: 8] = res;
                    default: cz_d[{k_q, 3'b000} +: 8] = res;
                endcase
                if (a_q < 2'd2) begin
                    a_d     = a_q + 2'd1;
                    state_d = LOAD;
                end else if (k_q < 3'd6) begin
                    k_d     = k_q + 3'd1;
                    state_d = CHECK;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            sx_q    <= '{default: '0};
            sy_q    <= '{default: '0};
            sz_q    <= '{default: '0};
            cnt_q   <= '{default: '0};
            cx_q    <= '0;
            cy_q    <= '0;
            cz_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            sz_q    <= sz_d;
            cnt_q   <= cnt_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cz_q    <= cz_d;
        end
    end

    assign bus.cx   = cx_q;
    assign bus.cy   = cy_q;
    assign bus.cz   = cz_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == FINISH);
endmodule

// File: tb/tb_kmeans_centroid_sched.sv
// Directed bench for kmeans_centroid_sched: init loading, mean computation, saturation,
// snapshot isolation, ignored inputs while busy and asynchronous abort.
`timescale 1ns/1ps
module tb_kmeans_centroid_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   busy_n, done_at, done_n;

    kmeans_centroid_sched_if #(.SUMW(16), .CNTW(6)) bus ();

    kmeans_centroid_sched #(.SUMW(16), .CNTW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        bus.start    = 1'b0;
        bus.sum_x    = '0;
        bus.sum_y    = '0;
        bus.sum_z    = '0;
        bus.cnt      = '0;
        bus.init_we  = 1'b0;
        bus.init_sel = '0;
        bus.init_x   = '0;
        bus.init_y   = '0;
        bus.init_z   = '0;
    endtask

    task automatic set_cl(input int k, input int c, input int x, input int y, input int z);
        bus.cnt[6*k +: 6]    = 6'(c);
        bus.sum_x[16*k +: 16] = 16'(x);
        bus.sum_y[16*k +: 16] = 16'(y);
        bus.sum_z[16*k +: 16] = 16'(z);
    endtask

    task automatic set_cfg_all();
        clear_in();
        for (int k = 0; k < 7; k++) set_cl(k, k + 1, 200 * (k + 1), 7 * (k + 1) + k, 0);
    endtask

    // Pulses start, scrambles sum/cnt one cycle later, then counts busy/done cycles (cycle 1 = first after E0).
    task automatic run(input int poke_at, input int rst_at,
                       output int b_n, output int d_at, output int d_n);
        b_n = 0; d_at = -1; d_n = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start   = 1'b0;
        bus.init_we = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.sum_x[16*i +: 16] = 16'($urandom());
            bus.sum_y[16*i +: 16] = 16'($urandom());
            bus.sum_z[16*i +: 16] = 16'($urandom());
            bus.cnt[6*i +: 6]     = 6'($urandom());
        end
        for (int c = 1; c <= 600; c++) begin
            if (c == rst_at) begin
                rst = 1'b1;
                break;
            end
            if (c == poke_at) begin
                bus.start = 1'b1; bus.init_we = 1'b1; bus.init_sel = 3'd0;
                bus.init_x = 8'd99; bus.init_y = 8'd99; bus.init_z = 8'd99;
            end
            if (c == poke_at + 1) begin
                bus.start = 1'b0; bus.init_we = 1'b0;
            end
            if (bus.busy) b_n++;
            if (bus.done) begin d_n++; d_at = c; end
            if (!bus.busy) break;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        clear_in();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_cx", 64'(bus.cx), 64'h0);
        chk("reset_cy", 64'(bus.cy), 64'h0);
        chk("reset_cz", 64'(bus.cz), 64'h0);
        chk("reset_busy", 64'(bus.busy), 64'h0);
        chk("reset_done", 64'(bus.done), 64'h0);

        bus.init_we = 1'b1; bus.init_sel = 3'd3;
        bus.init_x = 8'd10; bus.init_y = 8'd20; bus.init_z = 8'd30;
        @(posedge clk); #1;
        bus.init_we = 1'b0;
        chk("init3_cx", 64'(bus.cx), 64'h0000000A000000);
        chk("init3_cy", 64'(bus.cy), 64'h00000014000000);
        chk("init3_cz", 64'(bus.cz), 64'h0000001E000000);

        bus.init_we = 1'b1; bus.init_sel = 3'd7;
        bus.init_x = 8'd77; bus.init_y = 8'd77; bus.init_z = 8'd77;
        @(posedge clk); #1;
        bus.init_we = 1'b0;
        chk("init7_cx", 64'(bus.cx), 64'h0000000A000000);
        chk("init7_cy", 64'(bus.cy), 64'h00000014000000);
        chk("init7_cz", 64'(bus.cz), 64'h0000001E000000);

        // Single cluster; simultaneous init write to cluster 1 must be dropped.
        clear_in();
        set_cl(0, 4, 100, 41, 1020);
        bus.init_we = 1'b1; bus.init_sel = 3'd1;
        bus.init_x = 8'd55; bus.init_y = 8'd55; bus.init_z = 8'd55;
        run(0, 0, busy_n, done_at, done_n);
        chk("one_cx", 64'(bus.cx), 64'h0000000A000019);
        chk("one_cy", 64'(bus.cy), 64'h0000001400000A);
        chk("one_cz", 64'(bus.cz), 64'h0000001E0000FF);
        chk("one_busy_n", 64'(busy_n), 64'd62);
        chk("one_done_at", 64'(done_at), 64'd62);
        chk("one_done_n", 64'(done_n), 64'd1);
        chk("one_busy_fell", 64'(bus.busy), 64'h0);

        set_cfg_all();
        run(0, 0, busy_n, done_at, done_n);
        chk("all_cx", 64'(bus.cx), 64'hC8C8C8C8C8C8C8);
        chk("all_cy", 64'(bus.cy), 64'h07070707070707);
        chk("all_cz", 64'(bus.cz), 64'h00000000000000);
        chk("all_busy_n", 64'(busy_n), 64'd386);
        chk("all_done_at", 64'(done_at), 64'd386);
        chk("all_done_n", 64'(done_n), 64'd1);

        // Saturation/max values plus start+init_we poke at cycle 50 while busy.
        clear_in();
        set_cl(2, 1, 2000, 17, 300);
        set_cl(5, 63, 16065, 62, 314);
        set_cl(6, 41, 40, 10455, 10496);
        run(50, 0, busy_n, done_at, done_n);
        chk("sat_cx", 64'(bus.cx), 64'h00FFC8C8FFC8C8);
        chk("sat_cy", 64'(bus.cy), 64'hFF000707110707);
        chk("sat_cz", 64'(bus.cz), 64'hFF040000FF0000);
        chk("sat_busy_n", 64'(busy_n), 64'd170);
        chk("sat_done_at", 64'(done_at), 64'd170);
        chk("sat_done_n", 64'(done_n), 64'd1);

        clear_in();
        run(0, 0, busy_n, done_at, done_n);
        chk("zero_done_at", 64'(done_at), 64'd8);
        chk("zero_busy_n", 64'(busy_n), 64'd8);
        chk("zero_cx_kept", 64'(bus.cx), 64'h00FFC8C8FFC8C8);

        set_cfg_all();
        run(0, 100, busy_n, done_at, done_n);
        #1;
        chk("abort_busy", 64'(bus.busy), 64'h0);
        chk("abort_done", 64'(bus.done), 64'h0);
        chk("abort_cx", 64'(bus.cx), 64'h0);
        chk("abort_cy", 64'(bus.cy), 64'h0);
        chk("abort_cz", 64'(bus.cz), 64'h0);
        chk("abort_no_done", 64'(done_n), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        set_cfg_all();
        run(0, 0, busy_n, done_at, done_n);
        chk("rerun_cx", 64'(bus.cx), 64'hC8C8C8C8C8C8C8);
        chk("rerun_cy", 64'(bus.cy), 64'h07070707070707);
        chk("rerun_done_at", 64'(done_at), 64'd386);
        chk("rerun_done_n", 64'(done_n), 64'd1);
        chk("rerun_busy_fell", 64'(bus.busy), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
